// File: rtl/ha_pkg.sv
// Shared definitions for the NOR-only half-adder cell family.
package ha_pkg;

    // Cycles from an accepted beat to its result on the outputs.
    localparam int HA_LATENCY = 1;

    // Raw result of one half-adder lane before registering.
    typedef struct packed {
        logic s;
        logic c;
    } ha_res_t;

endpackage

// File: rtl/ha_nor_nor2.sv
// Two-input NOR primitive: the only gate used to build the half-adder lanes.
module nor2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a | b);

endmodule

// File: rtl/ha_nor.sv
// ha_nor: WIDTH independent half-adder lanes built from five NOR2 gates each,
// results registered once. Optional build macro HA_NOR_SELFCHECK_EN adds an
// err output comparing every accepted beat against behavioural XOR/AND.
//
// Handshake: a beat is accepted on every rising clk edge where in_valid=1
// (there is no ready; the block never stalls). out_valid is high for exactly
// the cycle after an accepted beat, and sum/cy hold their last result while
// out_valid is low.
module ha_nor
    import ha_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cy
`ifdef HA_NOR_SELFCHECK_EN
    ,
    output logic             err
`endif
);

    ha_res_t          res [WIDTH];
    logic [WIDTH-1:0] s_vec;
    logic [WIDTH-1:0] c_vec;

    // Per-lane netlist: n1=~a, n2=~b, c=a&b, n4=~(a|b), s=a^b.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic n1, n2, n4;
        nor2 u_n1 (.a(a[i]),     .b(a[i]),     .y(n1));
        nor2 u_n2 (.a(b[i]),     .b(b[i]),     .y(n2));
        nor2 u_c  (.a(n1),       .b(n2),       .y(res[i].c));
        nor2 u_n4 (.a(a[i]),     .b(b[i]),     .y(n4));
        nor2 u_s  (.a(res[i].c), .b(n4),       .y(res[i].s));
    end

    // Gather lane results into flat vectors for the output registers.
    always_comb begin
        s_vec = '0;
        c_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_vec[i] = res[i].s;
            c_vec[i] = res[i].c;
        end
    end

    // Output register: capture on accepted beats, hold data otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cy        <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            sum       <= s_vec;
            cy        <= c_vec;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef HA_NOR_SELFCHECK_EN
    // Self-check: flag any lane where the NOR netlist disagrees with XOR/AND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_valid) begin
            err <= (s_vec != (a ^ b)) || (c_vec != (a & b));
        end
    end
`endif

endmodule

// File: tb/tb_ha_nor.sv
// Self-checking bench for ha_nor (WIDTH=4). Build with HA_NOR_SELFCHECK_EN
// defined to also exercise the err output.
module tb_ha_nor;
    import ha_pkg::*;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] sum;
    logic [W-1:0] cy;
`ifdef HA_NOR_SELFCHECK_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    ha_nor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .sum      (sum),
        .cy       (cy)
`ifdef HA_NOR_SELFCHECK_EN
        ,
        .err      (err)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];      // {cy, sum} expected per accepted beat
    int             exp_cyc_q[$];  // cycle count at which it must appear
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: each lane is the 2-bit arithmetic sum of two bits.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] s, c;
        for (int i = 0; i < W; i++) begin
            int t;
            t = int'(av[i]) + int'(bv[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        in_valid = v;
        a        = av;
        b        = bv;
        if (v && rst_n) begin
            exp_q.push_back(model(av, bv));
            exp_cyc_q.push_back(cyc + HA_LATENCY);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] held_s, held_c;
        logic [2*W-1:0] e;
        int ec;
        held_s = '0;
        held_c = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                held_s = '0;
                held_c = '0;
                check("reset_ov", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ov", 32'(out_valid), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("latency", 32'(cyc), 32'(ec));
                    check("sum", 32'(sum), 32'(e[W-1:0]));
                    check("cy", 32'(cy), 32'(e[2*W-1:W]));
                    held_s = e[W-1:0];
                    held_c = e[2*W-1:W];
                end
            end else begin
                check("hold_sum", 32'(sum), 32'(held_s));
                check("hold_cy", 32'(cy), 32'(held_c));
                if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                    check("missing_ov", 32'(out_valid), 32'd1);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
`ifdef HA_NOR_SELFCHECK_EN
            check("err", 32'(err), 32'd0);
`endif
        end
    end

    task automatic async_reset_check(input string tag);
        check({tag, "_ov"}, 32'(out_valid), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cy"}, 32'(cy), 32'd0);
`ifdef HA_NOR_SELFCHECK_EN
        check({tag, "_err"}, 32'(err), 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        // Reset asserted with a=b=1 and valid driven, checked before any clk edge.
        in_valid = 1'b1;
        a        = '1;
        b        = '1;
        #1 rst_n = 1'b0;
        #2 async_reset_check("por");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All four input combinations in every lane, back to back.
        drive(1'b1, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0000, 4'b1111);
        drive(1'b1, 4'b1111, 4'b0000);
        drive(1'b1, 4'b1111, 4'b1111);

        // One carry beat, then idle with a changed: result must be held.
        drive(1'b1, 4'b1111, 4'b1111);
        drive(1'b0, 4'b0000, 4'b1111);
        drive(1'b0, 4'b0000, 4'b0000);

        // Mixed lanes.
        drive(1'b1, 4'b1100, 4'b1010);
        drive(1'b0, 4'b0000, 4'b0000);

        // Random traffic with random gaps.
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));

        // Reset asserted mid-stream while a valid beat is presented.
        drive(1'b1, 4'b1111, 4'b0000);
        drive(1'b1, 4'b0101, 4'b0110);
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1 async_reset_check("mid_rst");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'b0000, 4'b1111);
        drive(1'b0, 4'b0000, 4'b0000);

        // Exhaustive sweep of all lane input pairs.
        for (int i = 0; i < (1 << (2 * W)); i++) begin
            logic [2*W-1:0] v;
            v = (2 * W)'(i);
            drive(1'b1, v[2*W-1:W], v[W-1:0]);
        end

        // Drain and confirm every expected beat appeared.
        repeat (3) drive(1'b0, 4'b0000, 4'b0000);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
